// File: rtl/neuron_seq_ctrl.sv
// Time-multiplexed perceptron sequencer: one shared MAC per X element, then a
// signed threshold compare presented on a valid/ready result port.
module neuron_seq_ctrl #(
  parameter  int NUM_INPUTS = 18,
  parameter  int NUMO_BITS  = 4,
  parameter  int THR_BITS   = 8,
  localparam int AW         = $clog2(NUM_INPUTS),
  localparam int ACC_W      = 2*NUMO_BITS + AW
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        w_we,
  input  logic [AW-1:0]               w_addr,
  input  logic signed [NUMO_BITS-1:0] w_data,
  output logic                        w_busy,
  output logic                        cfg_err,
  input  logic signed [THR_BITS-1:0]  threshold,
  input  logic                        x_valid,
  input  logic signed [NUMO_BITS-1:0] x_data,
  output logic                        x_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        S,
  output logic signed [ACC_W-1:0]     acc_out
);

  typedef enum logic [1:0] {IDLE, ACCUM, RESULT} state_t;

  localparam logic [AW:0]   NUM_L = (AW+1)'(NUM_INPUTS);
  localparam logic [AW-1:0] LAST  = AW'(NUM_INPUTS - 1);
  localparam int            PW    = 2*NUMO_BITS;

  state_t                      state_q, state_d;
  logic [AW-1:0]               idx_q, idx_d;
  logic signed [ACC_W-1:0]     acc_q, acc_d;
  logic signed [ACC_W-1:0]     thr_q, thr_d;
  logic                        s_q, s_d;
  logic signed [ACC_W-1:0]     acc_out_q, acc_out_d;
  logic                        out_valid_q, out_valid_d;
  logic                        x_ready_q, x_ready_d;
  logic                        w_busy_q, w_busy_d;
  logic                        cfg_err_q, cfg_err_d;
  logic signed [NUMO_BITS-1:0] w_q [NUM_INPUTS];
  logic signed [NUMO_BITS-1:0] w_d [NUM_INPUTS];

  logic                        x_beat;
  logic                        addr_ok;
  logic signed [NUMO_BITS-1:0] w_sel;
  logic signed [PW-1:0]        prod;
  logic signed [ACC_W-1:0]     prod_ext;
  logic signed [ACC_W-1:0]     acc_sum;

  // Weight read uses the pre-write value, so a same-cycle write only affects later samples.
  always_comb begin
    w_sel    = w_q[idx_q];
    prod     = PW'(x_data) * PW'(w_sel);
    prod_ext = ACC_W'(prod);
    acc_sum  = acc_q + prod_ext;
    x_beat   = x_valid && x_ready_q;
    addr_ok  = ({1'b0, w_addr} < NUM_L);
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    thr_d       = thr_q;
    s_d         = s_q;
    acc_out_d   = acc_out_q;
    out_valid_d = out_valid_q;
    cfg_err_d   = cfg_err_q;
    w_d         = w_q;

    if (w_we) begin
      if (!w_busy_q && addr_ok) begin
        w_d[w_addr] = w_data;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (x_beat) begin
          acc_d   = prod_ext;
          thr_d   = ACC_W'(threshold);
          idx_d   = AW'(1);
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (x_beat) begin
          acc_d = acc_sum;
          if (idx_q == LAST) begin
            idx_d       = '0;
            state_d     = RESULT;
            out_valid_d = 1'b1;
            s_d         = (acc_sum >= thr_q);
            acc_out_d   = acc_sum;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
      RESULT: begin
        if (out_valid_q && out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake flags follow the next state so they are registered alongside it.
    x_ready_d = (state_d != RESULT);
    w_busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      thr_q       <= '0;
      s_q         <= 1'b0;
      acc_out_q   <= '0;
      out_valid_q <= 1'b0;
      x_ready_q   <= 1'b0;
      w_busy_q    <= 1'b0;
      cfg_err_q   <= 1'b0;
      for (int i = 0; i < NUM_INPUTS; i++) w_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      thr_q       <= thr_d;
      s_q         <= s_d;
      acc_out_q   <= acc_out_d;
      out_valid_q <= out_valid_d;
      x_ready_q   <= x_ready_d;
      w_busy_q    <= w_busy_d;
      cfg_err_q   <= cfg_err_d;
      w_q         <= w_d;
    end
  end

  assign w_busy    = w_busy_q;
  assign cfg_err   = cfg_err_q;
  assign x_ready   = x_ready_q;
  assign out_valid = out_valid_q;
  assign S         = s_q;
  assign acc_out   = acc_out_q;

endmodule

// File: tb/tb_neuron_seq_ctrl.sv
// Scoreboard bench for neuron_seq_ctrl: directed samples push expected results,
// a forked monitor pops and compares on every accepted output.
module tb_neuron_seq_ctrl;
  localparam int N = 18;

  logic              clk = 1'b0;
  logic              rst;
  logic              w_we;
  logic [4:0]        w_addr;
  logic signed [3:0] w_data;
  logic              w_busy;
  logic              cfg_err;
  logic signed [7:0] threshold;
  logic              x_valid;
  logic signed [3:0] x_data;
  logic              x_ready;
  logic              out_valid;
  logic              out_ready;
  logic              S;
  logic signed [12:0] acc_out;

  typedef struct {int acc; bit s;} exp_t;
  exp_t sb_q[$];

  int wm [N];
  int xv [N];
  int thr;
  int pass_cnt = 0;
  int total_cnt = 0;

  neuron_seq_ctrl dut (
    .clk(clk), .rst(rst), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .w_busy(w_busy), .cfg_err(cfg_err), .threshold(threshold),
    .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready),
    .out_valid(out_valid), .out_ready(out_ready), .S(S), .acc_out(acc_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = sb_q.pop_front();
          $display("result: acc_out=%0d S=%0d (expected %0d/%0d)", acc_out, S, e.acc, e.s);
          chk("acc_out", acc_out, e.acc);
          chk("S", S, e.s);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input int a, input int d, input bit ok);
    w_we = 1'b1; w_addr = 5'(a); w_data = 4'(d);
    tick();
    w_we = 1'b0;
    if (ok) wm[a] = d;
  endtask

  task automatic beat(input int x);
    int n = 0;
    x_valid = 1'b1; x_data = 4'(x);
    while (!x_ready && n < 200) begin tick(); n++; end
    if (!x_ready) chk("x_ready_timeout", x_ready, 1);
    tick();
    x_valid = 1'b0;
  endtask

  // mid_at >= 0: attempt a (dropped) write W[1]=3 before that beat.
  // sc_wr: write W[0]=-2 in the same cycle as the first beat.
  task automatic send_sample(input int gapmax, input int mid_at, input bit sc_wr);
    exp_t e;
    int a = 0;
    for (int i = 0; i < N; i++) a += xv[i] * wm[i];
    e.acc = a; e.s = (a >= thr);
    sb_q.push_back(e);
    $display("issue: thr=%0d expected acc=%0d S=%0d", thr, e.acc, e.s);
    threshold = 8'(thr);
    for (int i = 0; i < N; i++) begin
      if (gapmax > 0) repeat ($urandom_range(0, gapmax)) tick();
      if (i == mid_at) begin
        wr(1, 3, 1'b0);
        chk("w_busy_mid", w_busy, 1);
      end
      if (i == 0 && sc_wr) begin
        w_we = 1'b1; w_addr = 5'd0; w_data = -4'sd2;
      end
      beat(xv[i]);
      if (i == 0 && sc_wr) begin
        w_we = 1'b0;
        wm[0] = -2;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 500) begin tick(); n++; end
    chk("drain", sb_q.size(), 0);
  endtask

  task automatic set_x(input int x0, input int x1, input int x2, input int x3, input int rest);
    for (int i = 0; i < N; i++) xv[i] = rest;
    xv[0] = x0; xv[1] = x1; xv[2] = x2; xv[3] = x3;
  endtask

  initial begin
    rst = 1'b1; w_we = 1'b0; w_addr = '0; w_data = '0; threshold = '0;
    x_valid = 1'b0; x_data = '0; out_ready = 1'b1;
    for (int i = 0; i < N; i++) wm[i] = 0;
    fork monitor_loop(); join_none

    @(negedge clk);
    chk("x_ready_in_rst", x_ready, 0);
    chk("out_valid_in_rst", out_valid, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("x_ready_after_rst", x_ready, 1);
    chk("w_busy_after_rst", w_busy, 0);
    chk("cfg_err_after_rst", cfg_err, 0);
    chk("out_valid_after_rst", out_valid, 0);
    chk("S_after_rst", S, 0);
    chk("acc_out_after_rst", acc_out, 0);

    // Basic fire with latency / single-cycle valid
    wr(0, 1, 1); wr(1, 2, 1); wr(2, -3, 1); wr(3, 4, 1);
    set_x(2, 1, 1, 1, 0); thr = 1;
    send_sample(0, -1, 1'b0);
    chk("latency_valid", out_valid, 1);
    tick();
    chk("valid_one_cycle", out_valid, 0);
    drain();

    // Extremes
    for (int i = 0; i < 4; i++) wr(i, -8, 1);
    set_x(-8, -8, -8, 7, 0); thr = 127;
    send_sample(0, -1, 1'b0);
    drain();
    for (int i = 0; i < 4; i++) wr(i, 7, 1);
    set_x(-8, -8, -8, -8, -8); thr = -128;
    send_sample(0, -1, 1'b0);
    drain();

    // Backpressure: 7*(1+2+3+4) = 70
    out_ready = 1'b0;
    set_x(1, 2, 3, 4, 0); thr = 0;
    send_sample(0, -1, 1'b0);
    x_valid = 1'b1; x_data = 4'sd1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_acc_out", acc_out, 70);
      chk("bp_S", S, 1);
      chk("bp_x_ready", x_ready, 0);
      tick();
    end
    x_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_released_valid", out_valid, 0);
    chk("bp_x_ready_back", x_ready, 1);
    drain();

    // Config protection
    wr(18, 5, 1'b0);
    chk("cfg_err_bad_addr", cfg_err, 1);
    set_x(0, 1, 0, 0, 0); thr = 0;
    send_sample(0, 2, 1'b0);
    drain();
    chk("cfg_err_sticky", cfg_err, 1);
    set_x(1, 0, 0, 0, 0); thr = 0;
    send_sample(0, -1, 1'b1);
    drain();
    send_sample(0, -1, 1'b0);
    drain();

    // Gapped random stream with threshold +1
    for (int i = 0; i < N; i++) wr(i, int'($urandom_range(0, 15)) - 8, 1);
    thr = 1;
    for (int s = 0; s < 20; s++) begin
      for (int i = 0; i < N; i++) xv[i] = int'($urandom_range(0, 15)) - 8;
      send_sample(3, -1, 1'b0);
    end
    drain();

    // Reset mid-ACCUM
    threshold = 8'sd0;
    beat(1); beat(1);
    rst = 1'b1;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_acc_out", acc_out, 0);
    chk("rst_S", S, 0);
    chk("rst_x_ready", x_ready, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("rel_x_ready", x_ready, 1);
    chk("rel_w_busy", w_busy, 0);
    chk("rel_cfg_err", cfg_err, 0);
    for (int i = 0; i < N; i++) wm[i] = 0;
    set_x(3, 3, 3, 3, 3); thr = 0;
    send_sample(0, -1, 1'b0);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/neuron_seq_ctrl.md
Name: neuron_seq_ctrl

Overview:
Sequencer for a single time-multiplexed perceptron neuron. Holds NUM_INPUTS signed weights in an internal register file loaded through a config write port. Accepts one X element per handshake and applies one shared multiply-accumulate per element. After the last element it compares the sum with a threshold and presents the fire bit S on a valid/ready output. It replaces the fully parallel neuron wherever area matters more than throughput.

Parameters:
NUM_INPUTS, 18, elements per sample (>=2)
NUMO_BITS, 4, signed width of each X and W element
THR_BITS, 8, signed width of threshold (must be <= ACC_W)
ACC_W, 2*NUMO_BITS+$clog2(NUM_INPUTS), derived localparam, accumulator width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
w_we  in  1  weight write strobe
w_addr  in  $clog2(NUM_INPUTS)  weight index
w_data  in  NUMO_BITS  signed weight value
w_busy  out  1  high when weight writes are ignored (a sample is in progress)
cfg_err  out  1  sticky flag: write dropped (busy or addr out of range); cleared only by rst
threshold  in  THR_BITS  signed threshold; sampled on the first X beat of a sample
x_valid  in  1  X element valid
x_data  in  NUMO_BITS  signed X element, delivered in index order 0..NUM_INPUTS-1
x_ready  out  1  controller can accept an X element
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
S  out  1  fire bit: 1 when acc >= threshold
acc_out  out  ACC_W  signed final weighted sum (debug/visibility)

Behaviour:
- Reset (async, any state): state=IDLE; idx=0; acc=0; thr_q=0; S=0; acc_out=0; out_valid=0; x_ready=0 while rst is high, 1 from the first cycle after release; w_busy=0; cfg_err=0. Weight registers reset to 0.
- States: IDLE, ACCUM, RESULT.
- IDLE: x_ready=1, w_busy=0. On an X beat (x_valid&x_ready):
  - acc <= sext(x_data*W[0])
  - thr_q <= sext(threshold)
  - idx <= 1
  - go to ACCUM
- ACCUM: x_ready=1, w_busy=1. Each X beat: acc <= acc + sext(x_data*W[idx]), idx++. The beat with idx==NUM_INPUTS-1 goes to RESULT, idx <= 0. With no beat, everything holds; there is no timeout.
- RESULT: x_ready=0, w_busy=1. out_valid=1, S=(acc_final >= thr_q), signed compare at ACC_W. acc_out=acc_final. S and acc_out are registered and stable while out_valid&!out_ready. On out_valid&out_ready go to IDLE and out_valid <= 0. x_ready rises the following cycle, so results never overlap.
- Latency: out_valid rises the cycle after the last X beat is accepted. With continuous x_valid and out_ready, one sample takes NUM_INPUTS+1 cycles.
- Arithmetic:
  - Product: full 2*NUMO_BITS signed, sign-extended to ACC_W.
  - ACC_W guarantees no overflow; there is no saturation.
  - Threshold is sign-extended (threshold 8'h01 = +1).
- Weight writes:
  - Accepted only when w_busy=0 and w_addr<NUM_INPUTS; the weight is updated at that clock edge.
  - Otherwise the write is dropped and cfg_err <= 1.
  - Write and X beat in the same IDLE cycle: the write commits and the MAC uses the old W[0]. The new value applies from the next sample.
- Reset mid-sample or mid-RESULT: the partial sum and pending result are discarded, out_valid drops immediately, and the weights return to 0.
- S and acc_out keep their last values after the handshake (out_valid=0); they are meaningful only while out_valid=1.

Test Plan:
- Reset/idle: assert rst mid-ACCUM after 2 beats -> out_valid=0, acc_out=0, S=0, all W=0; after release x_ready=1, w_busy=0, cfg_err=0.
- Basic fire, NUM_INPUTS=4: W={1,2,-3,4}, X={2,1,1,1}, threshold=1, out_ready=1 -> acc_out=5, S=1, out_valid exactly 1 cycle after the 4th beat, for 1 cycle.
- Extremes and no fire, NUM_INPUTS=4: all W=-8, X={-8,-8,-8,7}, threshold=127 -> acc_out=136, S=1. Then threshold=-128 with W=7, X=-8 for all -> acc_out=-224, S=0.
- Backpressure: out_ready=0 for 5 cycles -> out_valid, S and acc_out held; x_ready=0 throughout. Release -> IDLE, next sample accepted one cycle later.
- Config protection: write W[1]=3 during ACCUM -> dropped, cfg_err=1, result uses the old W[1]. Write to addr=NUM_INPUTS in IDLE -> dropped. Write in the same cycle as the first beat -> the current sample uses the old W[0].
- Gapped stream, default 18 elements: random x_valid gaps with threshold=8'h01 -> acc_out and S match the reference dot product for 20 random samples.
